uart_txrx: RTL and testbench

Full-duplex 8N1 UART with one transmitter and one receiver sharing a clock and a bit-rate parameter. It converts a parallel byte plus strobe into a serial frame, and a serial frame into a parallel byte plus strobe. It sits between the system fabric and the board-level serial pins; loopback of TX to RX is a supported configuration.

---
 rtl/uart_txrx_if.sv | 22 ++
 rtl/uart_txrx.sv | 208 ++++++++++++++++++++
 tb/tb_uart_txrx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_txrx_if.sv
// Fabric/pin-side signal bundle for uart_txrx. The uart itself is the slave;
// whatever drives the byte strobe and the serial input line is the master.
interface uart_txrx_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;

  modport master (
    output i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    input  o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    output o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
  );
endinterface

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent TX and RX state machines sharing one
// clock and one bit-period parameter. Outputs decode straight from state flops.
module uart_txrx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  uart_txrx_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP, RX_WAIT_HIGH
  } rx_state_e;

  // ---------------------------------------------------------------- TX
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (bus.i_Tx_DV) begin
          tx_byte_d  = bus.i_Tx_Byte;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_idx_d   = '0;
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_CLEANUP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_CLEANUP: tx_state_d = TX_IDLE;
      default:    tx_state_d = TX_IDLE;
    endcase
  end

  // The line level is a pure function of state, so reset forces it high at once.
  always_comb begin
    bus.o_Tx_Active = 1'b0;
    bus.o_Tx_Done   = 1'b0;
    bus.o_Tx_Serial = 1'b1;
    unique case (tx_state_q)
      TX_START: begin
        bus.o_Tx_Active = 1'b1;
        bus.o_Tx_Serial = 1'b0;
      end
      TX_DATA: begin
        bus.o_Tx_Active = 1'b1;
        bus.o_Tx_Serial = tx_byte_q[tx_idx_q];
      end
      TX_STOP:    bus.o_Tx_Active = 1'b1;
      TX_CLEANUP: bus.o_Tx_Done   = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- RX
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [1:0]       rx_sync_q;
  logic             rx_line;
  logic             rx_bit_end;

  // Sync chain resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) rx_sync_q <= 2'b11;
    else          rx_sync_q <= {rx_sync_q[0], bus.i_Rx_Serial};
  end

  assign rx_line    = rx_sync_q[1];
  assign rx_bit_end = (rx_cnt_q == BIT_LAST);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        if (!rx_line) rx_state_d = RX_START;
      end
      RX_START: begin
        // Re-check at mid start bit; a high here was a glitch.
        if (rx_cnt_q == BIT_HALF) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rx_line;
          if (rx_idx_q == 3'd7) begin
            rx_idx_d   = '0;
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          if (rx_line) begin
            rx_byte_d  = rx_shift_q;
            rx_state_d = RX_CLEANUP;
          end else begin
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_CLEANUP:   rx_state_d = RX_IDLE;
      RX_WAIT_HIGH: if (rx_line) rx_state_d = RX_IDLE;
      default:      rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    bus.o_Rx_DV   = (rx_state_q == RX_CLEANUP);
    bus.o_Rx_Byte = rx_byte_q;
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: loopback frames, TX waveform, RX glitch and
// framing errors, busy/back-to-back strobes and mid-frame reset.
module tb_uart_txrx;
  localparam int CPB   = 87;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loop_en = 1'b0;
  logic rx_drv = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   dv_cnt = 0;
  int   done_cnt = 0;
  logic [7:0] sb[$];
  logic [7:0] mon_exp;

  uart_txrx_if bus();
  assign bus.i_Rx_Serial = loop_en ? bus.o_Tx_Serial : rx_drv;

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every DV must match the oldest expected byte.
  always @(negedge clk) begin
    if (bus.o_Tx_Done === 1'b1) done_cnt++;
    if (bus.o_Rx_DV === 1'b1) begin
      dv_cnt++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL rx_unexpected_dv: observed byte 0x%0h expected no DV", bus.o_Rx_Byte);
      end
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        chk("rx_byte", {24'd0, bus.o_Rx_Byte}, {24'd0, mon_exp});
      end
    end
  end

  // Caller must be sitting on a negedge. Sample i is taken i cycles after the accepting edge.
  task automatic send_and_watch(input logic [7:0] b);
    logic [9:0] frame;
    logic       exp_bit;
    logic [7:0] byte_at_done;
    int first_done, done_hi, act_hi, bad_bits, dv0, dv_at_done;
    frame = {1'b1, b, 1'b0};
    first_done = -1; done_hi = 0; act_hi = 0; bad_bits = 0;
    dv0 = dv_cnt; dv_at_done = dv_cnt; byte_at_done = 8'h00;
    if (loop_en) sb.push_back(b);
    bus.i_Tx_Byte = b;
    bus.i_Tx_DV   = 1'b1;
    for (int i = 0; i < FRAME + 4; i++) begin
      @(negedge clk);
      bus.i_Tx_DV = 1'b0;
      exp_bit = (i < FRAME) ? frame[i / CPB] : 1'b1;
      if (bus.o_Tx_Serial !== exp_bit) bad_bits++;
      if (bus.o_Tx_Active === 1'b1) act_hi++;
      if (bus.o_Tx_Done === 1'b1) begin
        done_hi++;
        if (first_done < 0) begin
          first_done   = i;
          byte_at_done = bus.o_Rx_Byte;
          dv_at_done   = dv_cnt;
        end
      end
    end
    chk("tx_bad_bit_cycles", bad_bits, 0);
    chk("tx_done_offset", first_done, FRAME);
    chk("tx_done_width", done_hi, 1);
    chk("tx_active_cycles", act_hi, FRAME);
    if (loop_en) begin
      chk("loop_byte_before_done", {24'd0, byte_at_done}, {24'd0, b});
      chk("loop_dv_before_done", dv_at_done - dv0, 1);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit good_stop);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 9; k++) begin
      rx_drv = frame[k];
      repeat (CPB) @(negedge clk);
    end
    if (good_stop) begin
      rx_drv = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx_drv = 1'b0;
      repeat (2 * CPB) @(negedge clk);
      rx_drv = 1'b1;
    end
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    int  v0, d0;
    bit  found;
    bus.i_Tx_DV   = 1'b0;
    bus.i_Tx_Byte = 8'h00;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", bus.o_Tx_Serial, 1);
    chk("rst_tx_active", bus.o_Tx_Active, 0);
    chk("rst_tx_done", bus.o_Tx_Done, 0);
    chk("rst_rx_dv", bus.o_Rx_DV, 0);
    chk("rst_rx_byte", bus.o_Rx_Byte, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // loopback frames
    loop_en = 1'b1;
    send_and_watch(8'hAB);
    repeat (10) @(negedge clk);
    send_and_watch(8'h3F);
    repeat (CPB) @(negedge clk);

    // RX glitch: short low pulse must not start a frame
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (10) @(negedge clk);
    v0 = dv_cnt;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_no_dv", dv_cnt - v0, 0);
    chk("glitch_byte_kept", bus.o_Rx_Byte, 8'h3F);

    // framing error then a good frame
    send_rx(8'h55, 1'b0);
    chk("frame_err_no_dv", dv_cnt - v0, 0);
    chk("frame_err_byte_kept", bus.o_Rx_Byte, 8'h3F);
    sb.push_back(8'hC3);
    send_rx(8'hC3, 1'b1);
    chk("after_err_dv", dv_cnt - v0, 1);
    chk("after_err_byte", bus.o_Rx_Byte, 8'hC3);

    // busy and back-to-back
    loop_en = 1'b1;
    repeat (CPB) @(negedge clk);
    v0 = dv_cnt; d0 = done_cnt;
    bus.i_Tx_Byte = 8'h00; bus.i_Tx_DV = 1'b1; sb.push_back(8'h00);
    @(negedge clk); bus.i_Tx_DV = 1'b0;
    repeat (400) @(negedge clk);
    bus.i_Tx_Byte = 8'hFF; bus.i_Tx_DV = 1'b1;
    @(negedge clk); bus.i_Tx_DV = 1'b0;
    found = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (bus.o_Tx_Done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("busy_done_seen", found, 1);
    bus.i_Tx_Byte = 8'h5A; bus.i_Tx_DV = 1'b1;
    @(negedge clk); bus.i_Tx_DV = 1'b0;
    chk("dv_in_done_ignored", bus.o_Tx_Active, 0);
    chk("dv_in_done_line", bus.o_Tx_Serial, 1);
    bus.i_Tx_Byte = 8'hFF; bus.i_Tx_DV = 1'b1; sb.push_back(8'hFF);
    @(negedge clk); bus.i_Tx_DV = 1'b0;
    chk("b2b_accepted", bus.o_Tx_Active, 1);
    repeat (FRAME + 50) @(negedge clk);
    chk("busy_dv_count", dv_cnt - v0, 2);
    chk("busy_done_count", done_cnt - d0, 2);
    chk("busy_sb_drained", sb.size(), 0);

    // reset in the middle of a loopback frame (TX data bit 4, RX mid-frame)
    v0 = dv_cnt; d0 = done_cnt;
    bus.i_Tx_Byte = 8'h96; bus.i_Tx_DV = 1'b1;
    @(negedge clk); bus.i_Tx_DV = 1'b0;
    repeat (5 * CPB + 40) @(negedge clk);
    chk("pre_rst_active", bus.o_Tx_Active, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_serial", bus.o_Tx_Serial, 1);
    chk("midrst_tx_active", bus.o_Tx_Active, 0);
    chk("midrst_tx_done", bus.o_Tx_Done, 0);
    chk("midrst_rx_dv", bus.o_Rx_DV, 0);
    chk("midrst_rx_byte", bus.o_Rx_Byte, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_no_dv", dv_cnt - v0, 0);
    send_and_watch(8'h42);
    repeat (20) @(negedge clk);
    chk("final_sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
